fd_bfloat16: RTL and testbench
==============================

# fd_bfloat16

Iterative bfloat16 divider, the inverse operation of the team's bfloat16 multiplier: computes num1 / num2 with one quotient bit per cycle through a restoring mantissa divider. It sits beside the multiplier in the approximate floating-point datapath and behind a valid/ready handshake on both sides. Results are truncated, not rounded, with fixed latency and simplified special-value handling.

## Interface
- No parameters; widths are fixed by the bfloat16 format.
- clk  input  1  clock, all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- num1  input  16  dividend {sign, exp[7:0], mant[6:0]}
- num2  input  16  divisor, same format
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  consumer accepts result
- out  output  16  quotient, bfloat16

## Operation
- States: IDLE -> DIV (9 cycles, counter 0..8) -> NORM (1 cycle) -> DONE -> IDLE.
- IDLE: in_ready=1; on in_valid, latch s=num1[15]^num2[15], ex1, ex2, A={1,num1[6:0]}, B={1,num2[6:0]}, remainder R=A (9 bits); go to DIV.
- DIV step: if R>=B then q bit=1, R=R-B, else q bit=0; then R=R<<1. First step produces q[8] (weight 2^0), last produces q[0] (weight 2^-8).
- NORM: if q[8]=1, mant=q[7:1], e=ex1-ex2+127; else mant=q[6:0], e=ex1-ex2+126. e computed signed, 10 bits.
- Result priority (first match wins): ex1==255 or ex2==255 -> 16'h7FC0; ex1==0 -> {s,15'h0000}; ex2==0 -> {s,8'hFF,7'h00}; e<=0 -> {s,15'h0000}; e>=255 -> {s,8'hFF,7'h00}; else {s,e[7:0],mant}.
- Special cases still traverse DIV/NORM; latency is data-independent.
- DONE: out_valid=1, out stable; on out_ready go to IDLE, out_valid drops next cycle; out retains last value.
- in_valid outside IDLE is ignored; operands are not re-sampled.

## Timing
- Accept edge E0 (in_valid & in_ready). DIV on edges E1-E9, NORM result registered at E10; out_valid high from E10 onward.
- Latency 10 cycles accept-to-out_valid; minimum initiation interval 12 cycles (DONE with out_ready=1, then IDLE).
- in_ready is a combinational decode of state==IDLE; no combinational path from in_valid or out_ready to any output.
- Reset (any state, asynchronous): state=IDLE, in_ready=1, out_valid=0, out=16'h0000, q, R, counter cleared. Reset during DIV discards the operation; no partial result appears.
- out_ready held low: out and out_valid hold indefinitely; in_ready stays 0.
- out_ready high in the same cycle out_valid rises: handshake completes on that edge.

## Structure
- Shared package fd_bf16_pkg: BF16_BIAS=127, BF16_EXP_MAX=8'hFF, BF16_QNAN=16'h7FC0, DIV_STEPS=9, state enum {IDLE, DIV, NORM, DONE}.
- One sub-module fd_mant_div: the 9-bit restoring remainder/quotient register and its step logic (start, step inputs; q[8:0] output). The FSM, exponent/sign logic and result packing stay in fd_bfloat16.

## Test plan
- 16'h4040 / 16'h3FC0 (3.0/1.5) -> out=16'h4000, out_valid exactly 10 cycles after accept.
- 16'h3F80 / 16'h4040 (1.0/3.0) -> out=16'h3EAA (truncated, not 16'h3EAB).
- 16'hC0C0 / 16'h4000 (-6.0/2.0) -> out=16'hC040.
- Specials: 16'h0000/16'h4000 -> 16'h0000; 16'h3F80/16'h0000 -> 16'h7F80; 16'h7F80/16'h3F80 -> 16'h7FC0; 16'h7F00/16'h0080 -> 16'h7F80; 16'h0080/16'h7F00 -> 16'h0000.
- Backpressure: out_ready low 5 cycles after out_valid -> out/out_valid stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle, in_ready=1.
- rst_n asserted mid-DIV (step 4) -> immediately out_valid=0, out=0, in_ready=1; next accepted operation produces correct result with normal latency.

Source files
------------

// File: rtl/fd_bf16_pkg.sv
// Shared constants and FSM state type for the iterative bfloat16 divider.
// Field widths come from the bfloat16 format: sign, 8-bit exponent, 7-bit mantissa.
package fd_bf16_pkg;

    localparam int          BF16_BIAS    = 127;
    localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam int          DIV_STEPS    = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/fd_bfloat16_if.sv
// Operand/result handshake bundle for fd_bfloat16.
// The divider core connects through the slave modport and its driver through the master modport.
interface fd_bfloat16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] num1;
    logic [15:0] num2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;

    modport master (
        output in_valid, num1, num2, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, num1, num2, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/fd_mant_div.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
// start loads the remainder with the dividend and latches the divisor for the whole run.
module fd_mant_div (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] q
);

    logic [8:0] r_reg;
    logic [8:0] r_next;
    logic [7:0] b_reg;
    logic [8:0] q_reg;
    logic [8:0] q_next;
    logic       ge;
    logic [7:0] diff;

    // After a subtraction the remainder is below the divisor, so it fits in 8 bits before the shift.
    always_comb begin
        ge     = (r_reg >= {1'b0, b_reg});
        diff   = ge ? 8'(r_reg - {1'b0, b_reg}) : r_reg[7:0];
        r_next = {diff, 1'b0};
    end

    assign q_next[0] = ge;

    generate
        for (genvar gi = 1; gi < 9; gi++) begin : g_qshift
            assign q_next[gi] = q_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= '0;
            b_reg <= '0;
            q_reg <= '0;
        end else if (start) begin
            r_reg <= {1'b0, a};
            b_reg <= b;
            q_reg <= '0;
        end else if (step) begin
            r_reg <= r_next;
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fd_bfloat16.sv
// Iterative bfloat16 divider (num1 / num2) with truncated result and fixed latency.
// Special operands still walk through DIV/NORM so timing never depends on data.
module fd_bfloat16
    import fd_bf16_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fd_bfloat16_if.slave  bus
);

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  cnt_reg;
    logic        s_reg;
    logic [7:0]  ex1_reg;
    logic [7:0]  ex2_reg;
    logic [15:0] out_reg;
    logic        start;
    logic        step;
    logic [8:0]  q;
    logic [6:0]  mant;
    logic signed [9:0] e_val;
    logic [15:0] result;

    fd_mant_div u_mant_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .step  (step),
        .a     ({1'b1, bus.num1[6:0]}),
        .b     ({1'b1, bus.num2[6:0]}),
        .q     (q)
    );

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    start      = 1'b1;
                    state_next = DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (cnt_reg == 4'(DIV_STEPS - 1)) state_next = NORM;
            end
            NORM: state_next = DONE;
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A quotient below 1.0 needs one extra left shift, hence the bias minus one.
    always_comb begin
        mant   = q[8] ? q[7:1] : q[6:0];
        e_val  = $signed({2'b00, ex1_reg}) - $signed({2'b00, ex2_reg})
               + (q[8] ? 10'(BF16_BIAS) : 10'(BF16_BIAS - 1));
        if (ex1_reg == BF16_EXP_MAX || ex2_reg == BF16_EXP_MAX)
            result = BF16_QNAN;
        else if (ex1_reg == 8'h00)
            result = {s_reg, 15'h0000};
        else if (ex2_reg == 8'h00)
            result = {s_reg, BF16_EXP_MAX, 7'h00};
        else if (e_val <= 10'sd0)
            result = {s_reg, 15'h0000};
        else if (e_val >= 10'sd255)
            result = {s_reg, BF16_EXP_MAX, 7'h00};
        else
            result = {s_reg, e_val[7:0], mant};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            s_reg     <= 1'b0;
            ex1_reg   <= '0;
            ex2_reg   <= '0;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                cnt_reg <= '0;
                s_reg   <= bus.num1[15] ^ bus.num2[15];
                ex1_reg <= bus.num1[14:7];
                ex2_reg <= bus.num2[14:7];
            end else if (step) begin
                cnt_reg <= cnt_reg + 4'd1;
            end
            if (state_reg == NORM) out_reg <= result;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out       = out_reg;

endmodule

// File: tb/tb_fd_bfloat16.sv
// Directed-vector bench for fd_bfloat16: arithmetic, specials, latency,
// backpressure and asynchronous reset in the middle of a division.
module tb_fd_bfloat16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fd_bfloat16_if bus ();

    fd_bfloat16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] sp_a   [5];
    logic [15:0] sp_b   [5];
    logic [15:0] sp_exp [5];

    // Accept one operation and wait (bounded) for out_valid; the result is left pending.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output int lat);
        @(negedge clk);
        bus.num1     = a;
        bus.num2     = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = bus.out;
        $display("op %h / %h -> %h latency %0d", a, b, res, lat);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 16'h0000) begin
            errors++;
            $display("FAIL reset: out_valid=%b in_ready=%b out=%h, required 0 1 0000",
                     bus.out_valid, bus.in_ready, bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [15:0] res;
        int lat;
        run_op(16'h4040, 16'h3FC0, res, lat);
        checks++;
        if (res !== 16'h4000) begin errors++; $display("FAIL div_3_1p5: out=%h required 4000", res); end
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL latency: %0d cycles required 10", lat); end
        release_out();
        run_op(16'h3F80, 16'h4040, res, lat);
        checks++;
        if (res !== 16'h3EAA) begin errors++; $display("FAIL div_1_3_trunc: out=%h required 3eaa", res); end
        release_out();
        run_op(16'hC0C0, 16'h4000, res, lat);
        checks++;
        if (res !== 16'hC040) begin errors++; $display("FAIL div_neg6_2: out=%h required c040", res); end
        release_out();
    endtask

    task automatic test_specials();
        logic [15:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(sp_a[i], sp_b[i], res, lat);
            checks++;
            if (res !== sp_exp[i] || lat !== 10) begin
                errors++;
                $display("FAIL special_%0d: out=%h latency=%0d required %h latency 10",
                         i, res, lat, sp_exp[i]);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] res;
        int lat;
        int bad;
        run_op(16'h3F80, 16'h4040, res, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out !== 16'h3EAA || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            bus.num1     = 16'h4040;
            bus.num2     = 16'h3F80;
            bus.in_valid = (i % 2 == 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad != 0 || bus.out !== 16'h3EAA || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold: %0d unstable cycles, out=%h out_valid=%b required 3eaa 1",
                     bad, bus.out, bus.out_valid);
        end
        release_out();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 16'h3EAA) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b out=%h required 0 1 3eaa",
                     bus.out_valid, bus.in_ready, bus.out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] res;
        int lat;
        bus.out_ready = 1'b1;
        run_op(16'hC0C0, 16'h4000, res, lat);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_take: out_valid=%b in_ready=%b required 0 1",
                     bus.out_valid, bus.in_ready);
        end
        run_op(16'h4040, 16'h3FC0, res, lat);
        checks++;
        if (res !== 16'h4000 || lat !== 10) begin
            errors++;
            $display("FAIL back_to_back: out=%h latency=%0d required 4000 latency 10", res, lat);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [15:0] res;
        int lat;
        int seen;
        @(negedge clk);
        bus.num1     = 16'h3F80;
        bus.num2     = 16'h4040;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b out=%h in_ready=%b required 0 0000 1",
                     bus.out_valid, bus.out, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL discarded_op: out_valid seen %0d cycles required 0", seen);
        end
        run_op(16'hC0C0, 16'h4000, res, lat);
        checks++;
        if (res !== 16'hC040 || lat !== 10) begin
            errors++;
            $display("FAIL after_reset: out=%h latency=%0d required c040 latency 10", res, lat);
        end
        release_out();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sp_a[0] = 16'h0000; sp_b[0] = 16'h4000; sp_exp[0] = 16'h0000;
        sp_a[1] = 16'h3F80; sp_b[1] = 16'h0000; sp_exp[1] = 16'h7F80;
        sp_a[2] = 16'h7F80; sp_b[2] = 16'h3F80; sp_exp[2] = 16'h7FC0;
        sp_a[3] = 16'h7F00; sp_b[3] = 16'h0080; sp_exp[3] = 16'h7F80;
        sp_a[4] = 16'h0080; sp_b[4] = 16'h7F00; sp_exp[4] = 16'h0000;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.num1      = 16'h0000;
        bus.num2      = 16'h0000;
        bus.out_ready = 1'b0;
        test_reset();
        test_arith();
        test_specials();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
